// File: rtl/imm_extend_unit.sv
// imm_extend_unit: widens a MIPS immediate (zero / sign / branch-shift / load-upper); IMMEXT_SKID_EN selects the skid build.
// Latency: 1 cycle (out_data is registered); sustains one item per cycle.
// Backpressure: skid build absorbs 2 items behind a registered in_ready; default build passes out_ready through to in_ready.
module imm_extend_unit #(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 16,
    parameter int BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode
);

    if (IN_W < 2 || BR_SHIFT < 0 || OUT_W < IN_W + BR_SHIFT) begin : g_bad_params
        $error("imm_extend_unit: need IN_W >= 2, BR_SHIFT >= 0, OUT_W >= IN_W + BR_SHIFT");
    end

    typedef struct packed {
        logic [1:0]       mode;
        logic [OUT_W-1:0] data;
    } item_t;

    item_t            new_item;
    item_t            main_q;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] upper;
    logic             in_xfer;
    logic             out_xfer;
    logic             load_main;

    always_comb begin
        zext            = '0;
        zext[IN_W-1:0]  = in_imm;
        sext            = {OUT_W{in_imm[IN_W-1]}};
        sext[IN_W-1:0]  = in_imm;
        upper           = '0;
        upper[OUT_W-1 -: IN_W] = in_imm;
        new_item.mode   = in_mode;
        new_item.data   = '0;
        unique case (in_mode)
            2'b00:   new_item.data = zext;
            2'b01:   new_item.data = sext;
            // OUT_W >= IN_W + BR_SHIFT guarantees only sign copies fall off the top
            2'b10:   new_item.data = sext << BR_SHIFT;
            default: new_item.data = upper;
        endcase
    end

`ifdef IMMEXT_SKID_EN
    typedef enum logic [1:0] {EMPTY, MAIN, FULL} state_t;
    state_t state_q;
    state_t state_d;
    item_t  skid_q;
    logic   load_skid;
    logic   main_from_skid;

    // FULL is exactly "skid valid", so in_ready never looks at out_ready
    assign in_ready = (state_q != FULL) && !rst;
`else
    typedef enum logic {EMPTY, MAIN} state_t;
    state_t state_q;
    state_t state_d;

    assign in_ready = !rst && (!out_valid || out_ready);
`endif

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q.data;
    assign out_mode  = main_q.mode;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
`ifdef IMMEXT_SKID_EN
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: if (in_xfer) begin
                state_d   = MAIN;
                load_main = 1'b1;
            end
            MAIN: begin
                if (in_xfer && !out_xfer) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: if (out_xfer) begin
                state_d        = MAIN;
                main_from_skid = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
`else
        case (state_q)
            EMPTY: if (in_xfer) begin
                state_d   = MAIN;
                load_main = 1'b1;
            end
            // in_ready implies out_ready here, so an accept is always a replace
            MAIN: begin
                if (in_xfer) begin
                    load_main = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
`ifdef IMMEXT_SKID_EN
            skid_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_q <= new_item;
            end
`ifdef IMMEXT_SKID_EN
            else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= new_item;
            end
`endif
        end
    end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed bench for imm_extend_unit: 8->16 instance with a scoreboard, plus a 16->32 instance for the parameter sweep.
module tb_imm_extend_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_mode;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [15:0] w_in_imm;
    logic [1:0]  w_in_mode;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [31:0] w_out_data;
    logic [1:0]  w_out_mode;

    int errors = 0;
    int checks = 0;
    logic acc;

    typedef struct packed {
        logic [1:0]  mode;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    imm_extend_unit #(.IN_W(8), .OUT_W(16), .BR_SHIFT(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
    );

    imm_extend_unit #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_imm(w_in_imm), .in_mode(w_in_mode),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data), .out_mode(w_out_mode)
    );

    function automatic logic [15:0] model(input logic [7:0] imm, input logic [1:0] md);
        logic [15:0] s;
        s = {{8{imm[7]}}, imm};
        case (md)
            2'b00:   return {8'h00, imm};
            2'b01:   return s;
            2'b10:   return {s[13:0], 2'b00};
            default: return {imm, 8'h00};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge: drive, settle, score the transfers of the coming rising edge.
    task automatic cycle(input logic iv, input logic [7:0] imm, input logic [1:0] md, input logic ordy);
        exp_t e;
        in_valid  = iv;
        in_imm    = imm;
        in_mode   = md;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out: observed=%h expected=none", out_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_data", {16'h0, out_data}, {16'h0, e.data});
                chk("sb_mode", {30'h0, out_mode}, {30'h0, e.mode});
            end
        end
        if (acc) begin
            e.mode = md;
            e.data = model(imm, md);
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle32(input logic [15:0] imm, input logic [1:0] md, input logic [31:0] expv, input string tag);
        w_in_valid = 1'b1;
        w_in_imm   = imm;
        w_in_mode  = md;
        @(posedge clk);
        @(negedge clk);
        w_in_valid = 1'b0;
        #1;
        chk({tag, "_vld"}, {31'h0, w_out_valid}, 32'h1);
        chk(tag, w_out_data, expv);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_imm = '0; w_in_mode = '0; w_out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", {16'h0, out_data}, 32'h0);
        chk("rst_out_mode", {30'h0, out_mode}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Modes, one-cycle latency, spec constants
        cycle(1'b1, 8'h9C, 2'b00, 1'b1);
        chk("zero_vld", {31'h0, out_valid}, 32'h1);
        chk("zero", {16'h0, out_data}, 32'h009C);
        cycle(1'b1, 8'h9C, 2'b01, 1'b1);
        chk("sign", {16'h0, out_data}, 32'hFF9C);
        cycle(1'b1, 8'h9C, 2'b10, 1'b1);
        chk("branch", {16'h0, out_data}, 32'hFE70);
        chk("branch_mode", {30'h0, out_mode}, 32'h2);
        cycle(1'b1, 8'h9C, 2'b11, 1'b1);
        chk("upper", {16'h0, out_data}, 32'h9C00);
        cycle(1'b0, 8'h00, 2'b00, 1'b1);
        chk("drain_vld", {31'h0, out_valid}, 32'h0);

        // Streaming: 16 back-to-back items
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 2'b01, 1'b1);
            chk("stream_acc", {31'h0, acc}, 32'h1);
            chk("stream_out", {16'h0, out_data}, 32'(i));
        end
        cycle(1'b0, 8'h00, 2'b00, 1'b1);

        // Back-pressure
`ifdef IMMEXT_SKID_EN
        cycle(1'b1, 8'h11, 2'b01, 1'b0);
        chk("bp_acc11", {31'h0, acc}, 32'h1);
        cycle(1'b1, 8'h22, 2'b01, 1'b0);
        chk("bp_acc22", {31'h0, acc}, 32'h1);
        chk("bp_full_in_ready", {31'h0, in_ready}, 32'h0);
        cycle(1'b1, 8'h33, 2'b01, 1'b0);
        chk("bp_rej33", {31'h0, acc}, 32'h0);
        cycle(1'b1, 8'h33, 2'b01, 1'b1);
        chk("bp_rej33_release", {31'h0, acc}, 32'h0);
        chk("bp_ready_after_release", {31'h0, in_ready}, 32'h1);
        chk("bp_skid_presented", {16'h0, out_data}, 32'h0022);
        cycle(1'b1, 8'h33, 2'b01, 1'b1);
        chk("bp_acc33", {31'h0, acc}, 32'h1);
`else
        cycle(1'b1, 8'h11, 2'b01, 1'b0);
        chk("bp_acc11", {31'h0, acc}, 32'h1);
        cycle(1'b1, 8'h22, 2'b01, 1'b0);
        chk("bp_rej22", {31'h0, acc}, 32'h0);
        cycle(1'b1, 8'h22, 2'b01, 1'b1);
        chk("bp_acc22", {31'h0, acc}, 32'h1);
        cycle(1'b1, 8'h33, 2'b01, 1'b1);
        chk("bp_acc33", {31'h0, acc}, 32'h1);
`endif
        chk("bp_out33", {16'h0, out_data}, 32'h0033);
        cycle(1'b0, 8'h00, 2'b00, 1'b1);

        // Simultaneous in/out transfer while holding one item
        cycle(1'b1, 8'h5A, 2'b10, 1'b1);
        cycle(1'b1, 8'hA5, 2'b00, 1'b1);
        chk("simul_acc", {31'h0, acc}, 32'h1);
        chk("simul_vld", {31'h0, out_valid}, 32'h1);
        chk("simul_data", {16'h0, out_data}, 32'h00A5);
        cycle(1'b0, 8'h00, 2'b00, 1'b1);
        chk("simul_drained", {31'h0, out_valid}, 32'h0);

        // Reset mid-operation with buffered items
        cycle(1'b1, 8'h77, 2'b01, 1'b0);
        cycle(1'b1, 8'h88, 2'b01, 1'b0);
        rst = 1'b1;
        in_valid = 1'b1; in_imm = 8'h99; out_ready = 1'b1;
        #1;
        chk("midrst_in_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_out_data", {16'h0, out_data}, 32'h0);
        chk("midrst_in_ready2", {31'h0, in_ready}, 32'h0);
        rst = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #1;
        chk("midrst_release_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 2'b00, 1'b1);
            chk("midrst_no_stale", {31'h0, out_valid}, 32'h0);
        end

        // Parameter sweep on the 16->32 instance
        cycle32(16'h8001, 2'b00, 32'h00008001, "w_zero");
        cycle32(16'h8001, 2'b01, 32'hFFFF8001, "w_sign");
        cycle32(16'h8001, 2'b10, 32'hFFFE0004, "w_branch");
        cycle32(16'h8001, 2'b11, 32'h80010000, "w_upper");

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_extend_unit.md
# imm_extend_unit

Parametrised, pipelined immediate-extension stage for the MIPS datapath. Widens an IN_W-bit immediate to OUT_W bits in one of four modes: zero-extend, sign-extend, sign-extend-and-shift for branch offsets, and load-upper. It sits between instruction decode and the ALU operand mux, with a valid/ready handshake on both sides so decode back-pressure can stall it without losing data.

## Interface

Parameters:
- IN_W, default 8: immediate input width, ≥ 2.
- OUT_W, default 16: extended output width. Must satisfy OUT_W ≥ IN_W + BR_SHIFT; elaboration fails otherwise.
- BR_SHIFT, default 2: left shift applied in branch mode, ≥ 0.

Ports:
- clk, input, 1: sole clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: in_imm and in_mode are valid.
- in_ready, output, 1: the unit accepts input this cycle.
- in_imm, input, IN_W: raw immediate.
- in_mode, input, 2: extension mode. 00 = zero, 01 = sign, 10 = branch, 11 = upper.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: the consumer accepts out_data this cycle.
- out_data, output, OUT_W: extended result.
- out_mode, output, 2: in_mode that travels with out_data.

## Operation

- An input transfer happens on a rising edge where in_valid && in_ready. An output transfer happens on a rising edge where out_valid && out_ready.
- Arithmetic, computed on the accepted in_imm:
  - zero: upper OUT_W−IN_W bits are 0; low bits are in_imm.
  - sign: upper bits replicate in_imm[IN_W−1]; low bits are in_imm.
  - branch: sign-extend, then shift left by BR_SHIFT with zero fill. No bits are lost, because of the OUT_W constraint.
  - upper: in_imm goes to out_data[OUT_W−1 : OUT_W−IN_W]; all lower bits are 0.
- The result and mode are computed before registering. out_data is driven only from registers.
- Data ordering is strictly FIFO. Nothing is dropped or duplicated.
- Once out_valid is high, out_data and out_mode stay stable until the output transfer completes.
- When out_valid is low, out_data holds its last value. Consumers ignore it.
- State machine (with IMMEXT_SKID_EN defined):
  - EMPTY: main register invalid.
    - Input transfer → MAIN.
  - MAIN: main register valid, skid register invalid.
    - Input without output → FULL; the new item goes to skid.
    - Output without input → EMPTY.
    - Input and output together → stay in MAIN; main is reloaded with the new item.
  - FULL: main and skid both valid; in_ready = 0.
    - Output transfer → MAIN; skid moves to main.
- Reset:
  - Returns to EMPTY.
  - out_valid = 0, out_data = 0, out_mode = 00, skid cleared.
  - in_ready = 0 while rst is high.
  - Any item in flight when rst asserts is discarded, with no output transfer.

## Timing

- Latency: an item accepted at edge N shows out_valid = 1 in the cycle after edge N.
- Throughput: one item per cycle while out_ready is held high.
- in_ready with skid:
  - It is a register-derived signal: in_ready = !skid_valid && !rst.
  - There is no combinational path from out_ready.
  - The first cycle after reset deasserts has in_ready = 1.
- Stall: while out_ready = 0 the unit absorbs at most 2 items, then in_ready falls on the edge that fills skid.
- When FULL and out_ready rises at edge M:
  - in_ready = 1 in the cycle after M.
  - The skid item is presented on out_data in the same cycle.
- in_valid may rise or fall at any time. Unaccepted inputs have no effect.
- rst overrides every simultaneous transfer on the same edge.

## Configuration

- IMMEXT_SKID_EN defined:
  - Two-entry skid buffer as described above.
  - Registered in_ready.
  - Full throughput under back-pressure.
- IMMEXT_SKID_EN undefined:
  - Single output register only; states are EMPTY and MAIN.
  - in_ready = !rst && (!out_valid || out_ready). This is a combinational path from out_ready.
  - Same latency, same full throughput. At most 1 item is buffered.
- Arithmetic, ordering and reset behaviour are identical in both builds.

## Test plan

- Modes, IN_W = 8, OUT_W = 16, BR_SHIFT = 2, out_ready = 1. Feed in_imm = 0x9C in each mode; the next cycle must show:
  - zero → 0x009C
  - sign → 0xFF9C
  - branch → 0xFE70
  - upper → 0x9C00
- Streaming: 16 back-to-back items 0x00..0x0F in sign mode with out_ready = 1 → outputs 0x0000..0x000F on 16 consecutive cycles, in_ready never low.
- Back-pressure (skid build): hold out_ready = 0 and offer 0x11, 0x22, 0x33 →
  - only 0x11 and 0x22 are accepted; in_ready = 0 after the second accept;
  - releasing out_ready yields 0x0011 then 0x0022, then 0x33 is accepted.
- Simultaneous: in MAIN, assert an input and an output transfer on the same edge → state stays MAIN; the next out_data is the new item; no gaps, no duplicates.
- Reset mid-operation: FULL with 2 items, assert rst for 1 cycle →
  - out_valid = 0, out_data = 0x0000, in_ready = 0 during rst;
  - in_ready = 1 the next cycle;
  - neither old item ever appears on the output.
- Parameter sweep: IN_W = 16, OUT_W = 32, BR_SHIFT = 2, in_imm = 0x8001 →
  - sign → 0xFFFF8001
  - branch → 0xFFFE0004
  - upper → 0x80010000
